clm_rand_feeder: RTL and testbench

CLM_RAND_FEEDER -- requirements
Module: clm_rand_feeder

---
 rtl/clm_rand_feeder.sv | 113 +++++++++++
 tb/tb_clm_rand_feeder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/clm_rand_feeder.sv
// clm_rand_feeder: fills a bank of NWORDS 16-bit words from a 16-bit Galois LFSR
// and hands the complete bank to the Sub-bytes stage on each take.
// Optional feature macro: CLM_RAND_STALL_CNT_EN adds a saturating stall_cnt
// output that counts takes arriving while no fill is ready.
module clm_rand_feeder #(
   parameter int NWORDS = 7
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   seed_valid,
   input  logic [15:0]            seed,
   input  logic                   take,
   output logic [NWORDS*16-1:0]   random_vect,
   output logic                   r_valid,
   output logic                   take_err
`ifdef CLM_RAND_STALL_CNT_EN
   ,
   output logic [15:0]            stall_cnt
`endif
);

   localparam int          CW        = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(NWORDS - 1);
   localparam logic [15:0] SEED_ZERO_SUB = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS     = 16'hB400;

   typedef enum logic [1:0] {
      UNSEEDED = 2'd0,
      FILL     = 2'd1,
      READY    = 2'd2
   } state_t;

   state_t                 state, state_next;
   logic [15:0]            lfsr, lfsr_next;
   logic [CW-1:0]          cnt, cnt_next;
   logic [NWORDS*16-1:0]   vect_next;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
   endfunction

   // Next-state logic: a seed always restarts the fill; otherwise fill words one per cycle until the bank is full, then wait for take.
   always_comb begin
      state_next = state;
      lfsr_next  = lfsr;
      cnt_next   = cnt;
      vect_next  = random_vect;
      if (seed_valid) begin
         lfsr_next  = (seed == 16'h0000) ? SEED_ZERO_SUB : seed;
         cnt_next   = '0;
         state_next = FILL;
      end else begin
         case (state)
            UNSEEDED: begin
               state_next = UNSEEDED;
            end
            FILL: begin
               for (int i = NWORDS - 1; i > 0; i--) begin
                  vect_next[16*i +: 16] = random_vect[16*(i-1) +: 16];
               end
               vect_next[15:0] = lfsr;
               lfsr_next       = lfsr_step(lfsr);
               if (cnt == CNT_LAST) begin
                  cnt_next   = '0;
                  state_next = READY;
               end else begin
                  cnt_next = cnt + 1'b1;
               end
            end
            READY: begin
               if (take) begin
                  cnt_next   = '0;
                  state_next = FILL;
               end
            end
            default: begin
               state_next = UNSEEDED;
            end
         endcase
      end
   end

   // State register plus the registered status flags; take_err flags a take that found no ready bank.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= UNSEEDED;
         lfsr        <= SEED_ZERO_SUB;
         cnt         <= '0;
         random_vect <= '0;
         r_valid     <= 1'b0;
         take_err    <= 1'b0;
      end else begin
         state       <= state_next;
         lfsr        <= lfsr_next;
         cnt         <= cnt_next;
         random_vect <= vect_next;
         r_valid     <= (state_next == READY);
         take_err    <= take & ~r_valid;
      end
   end

`ifdef CLM_RAND_STALL_CNT_EN
   // Saturating count of takes that arrived while no bank was ready; only reset clears it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt <= 16'h0000;
      end else if (take && !r_valid && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'h0001;
      end
   end
`endif

endmodule

// File: tb/tb_clm_rand_feeder.sv
// tb_clm_rand_feeder: directed-vector bench for clm_rand_feeder with hand-computed
// LFSR fill patterns. Handles builds with or without CLM_RAND_STALL_CNT_EN.
module tb_clm_rand_feeder;

   localparam int NWORDS = 7;

   logic                  clk;
   logic                  rst;
   logic                  seed_valid;
   logic [15:0]           seed;
   logic                  take;
   logic [NWORDS*16-1:0]  random_vect;
   logic                  r_valid;
   logic                  take_err;
`ifdef CLM_RAND_STALL_CNT_EN
   logic [15:0]           stall_cnt;
`endif

   int vectorCount;
   int missCount;

   logic [NWORDS*16-1:0]  savedVect;

   clm_rand_feeder #(.NWORDS(NWORDS)) dut (
      .clk         (clk),
      .rst         (rst),
      .seed_valid  (seed_valid),
      .seed        (seed),
      .take        (take),
      .random_vect (random_vect),
      .r_valid     (r_valid),
      .take_err    (take_err)
`ifdef CLM_RAND_STALL_CNT_EN
      ,
      .stall_cnt   (stall_cnt)
`endif
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle of inputs, let the edge happen, then return to idle inputs 1 ns later
   task automatic applyStimulus(input logic r, input logic sv, input logic [15:0] s, input logic tk);
      rst        = r;
      seed_valid = sv;
      seed       = s;
      take       = tk;
      @(posedge clk);
      #1;
      rst        = 1'b1;
      seed_valid = 1'b0;
      seed       = 16'h0000;
      take       = 1'b0;
   endtask

   // Count one comparison and report it when it misses
   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   function automatic logic [NWORDS*16-1:0] packWords(input logic [15:0] w6, input logic [15:0] w5,
                                                      input logic [15:0] w4, input logic [15:0] w3,
                                                      input logic [15:0] w2, input logic [15:0] w1,
                                                      input logic [15:0] w0);
      return {w6, w5, w4, w3, w2, w1, w0};
   endfunction

   // Directed scenario sequence
   initial begin
      vectorCount = 0;
      missCount   = 0;
      rst        = 1'b0;
      seed_valid = 1'b0;
      seed       = 16'h0000;
      take       = 1'b0;

      // reset state
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      checkOutput("reset_r_valid",  128'(r_valid),     128'(1'b0));
      checkOutput("reset_vect",     128'(random_vect), 128'(0));
      checkOutput("reset_take_err", 128'(take_err),    128'(1'b0));
`ifdef CLM_RAND_STALL_CNT_EN
      checkOutput("reset_stall_cnt", 128'(stall_cnt), 128'(16'h0000));
`endif
      applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
      checkOutput("unseeded_r_valid", 128'(r_valid), 128'(1'b0));

      // take while unseeded
      applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
      checkOutput("unseeded_take_err", 128'(take_err), 128'(1'b1));
      checkOutput("unseeded_vect_hold", 128'(random_vect), 128'(0));
      applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
      checkOutput("unseeded_take_err_drop", 128'(take_err), 128'(1'b0));

      // seed 0001 with a stray take on fill cycle 3
      applyStimulus(1'b1, 1'b1, 16'h0001, 1'b0);
      checkOutput("seed1_r_valid_low", 128'(r_valid), 128'(1'b0));
      for (int k = 1; k <= 7; k++) begin
         applyStimulus(1'b1, 1'b0, 16'h0000, (k == 3) ? 1'b1 : 1'b0);
         if (k == 3) checkOutput("midfill_take_err", 128'(take_err), 128'(1'b1));
         if (k == 4) checkOutput("midfill_take_err_drop", 128'(take_err), 128'(1'b0));
         if (k == 6) checkOutput("seed1_r_valid_c6", 128'(r_valid), 128'(1'b0));
      end
      checkOutput("seed1_r_valid_c7", 128'(r_valid), 128'(1'b1));
      checkOutput("seed1_vect", 128'(random_vect),
                  128'(packWords(16'h0001, 16'hB400, 16'h5A00, 16'h2D00, 16'h1680, 16'h0B40, 16'h05A0)));
`ifdef CLM_RAND_STALL_CNT_EN
      checkOutput("stall_cnt_two", 128'(stall_cnt), 128'(16'h0002));
`endif

      // ready holds its bank
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
      checkOutput("ready_hold_r_valid", 128'(r_valid), 128'(1'b1));
      checkOutput("ready_hold_vect", 128'(random_vect),
                  128'(packWords(16'h0001, 16'hB400, 16'h5A00, 16'h2D00, 16'h1680, 16'h0B40, 16'h05A0)));

      // take in READY, refill continues the LFSR
      savedVect = packWords(16'h0001, 16'hB400, 16'h5A00, 16'h2D00, 16'h1680, 16'h0B40, 16'h05A0);
      applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
      checkOutput("take_r_valid_drop", 128'(r_valid), 128'(1'b0));
      checkOutput("take_no_err", 128'(take_err), 128'(1'b0));
      checkOutput("take_vect_stable", 128'(random_vect), 128'(savedVect));
      for (int k = 1; k <= 6; k++) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
      checkOutput("refill_r_valid_c6", 128'(r_valid), 128'(1'b0));
      applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
      checkOutput("refill_r_valid_c7", 128'(r_valid), 128'(1'b1));
      checkOutput("refill_vect", 128'(random_vect),
                  128'(packWords(16'h02D0, 16'h0168, 16'h00B4, 16'h005A, 16'h002D, 16'hB416, 16'h5A0B)));
      checkOutput("refill_no_err", 128'(take_err), 128'(1'b0));

      // seed 0000 behaves like seed ACE1
      applyStimulus(1'b1, 1'b1, 16'h0000, 1'b0);
      for (int k = 1; k <= 7; k++) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
      checkOutput("seed0_r_valid", 128'(r_valid), 128'(1'b1));
      checkOutput("seed0_vect", 128'(random_vect),
                  128'(packWords(16'hACE1, 16'hE270, 16'h7138, 16'h389C, 16'h1C4E, 16'h0E27, 16'hB313)));

      // reseed during fill restarts from the new seed
      applyStimulus(1'b1, 1'b1, 16'h0001, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'h1234, 1'b0);
      for (int k = 1; k <= 6; k++) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
      checkOutput("reseed_r_valid_c6", 128'(r_valid), 128'(1'b0));
      applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
      checkOutput("reseed_r_valid_c7", 128'(r_valid), 128'(1'b1));
      checkOutput("reseed_vect", 128'(random_vect),
                  128'(packWords(16'h1234, 16'h091A, 16'h048D, 16'hB646, 16'h5B23, 16'h9991, 16'hF8C8)));

      // seed and take on the same edge while READY: seed wins, no error
      applyStimulus(1'b1, 1'b1, 16'h0001, 1'b1);
      checkOutput("same_edge_take_err", 128'(take_err), 128'(1'b0));
      checkOutput("same_edge_r_valid", 128'(r_valid), 128'(1'b0));
      // seed and take on the same edge while filling: error raised
      applyStimulus(1'b1, 1'b1, 16'h0001, 1'b1);
      checkOutput("same_edge_fill_take_err", 128'(take_err), 128'(1'b1));
      for (int k = 1; k <= 7; k++) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
      checkOutput("same_edge_vect", 128'(random_vect),
                  128'(packWords(16'h0001, 16'hB400, 16'h5A00, 16'h2D00, 16'h1680, 16'h0B40, 16'h05A0)));
      checkOutput("same_edge_ready", 128'(r_valid), 128'(1'b1));

      // reset while READY with take asserted
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
      checkOutput("rst_ready_vect", 128'(random_vect), 128'(0));
      checkOutput("rst_ready_r_valid", 128'(r_valid), 128'(1'b0));
      checkOutput("rst_ready_take_err", 128'(take_err), 128'(1'b0));
`ifdef CLM_RAND_STALL_CNT_EN
      checkOutput("rst_stall_cnt", 128'(stall_cnt), 128'(16'h0000));
`endif
      applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
      checkOutput("post_rst_r_valid", 128'(r_valid), 128'(1'b0));
      applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
      checkOutput("post_rst_take_err", 128'(take_err), 128'(1'b1));
`ifdef CLM_RAND_STALL_CNT_EN
      checkOutput("post_rst_stall_cnt", 128'(stall_cnt), 128'(16'h0001));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
